// File: rtl/mult_rca.sv
// Sequential radix-2 shift-and-add unsigned multiplier.
// One multiplier bit is consumed per clock through an N-bit ripple-carry adder.

module mult_rca_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module mult_rca_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);
  logic [N:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar g = 0; g < N; g++) begin : g_fa
    mult_rca_fa u_fa (
      .i_a  (i_a[g]),
      .i_b  (i_b[g]),
      .i_c  (w_carry[g]),
      .o_s  (o_sum[g]),
      .o_co (w_carry[g+1])
    );
  end

  assign o_cout = w_carry[N];
endmodule

// state | meaning
// IDLE  | waiting for start; product holds last result
// CALC  | N shift-and-add iterations in progress
// DONE  | publish product and pulse valid, then back to IDLE
module mult_rca #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplier,
  input  logic [N-1:0]   multiplicand,
  output logic [2*N-1:0] product,
  output logic           valid
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [N-1:0]   r_m;
  logic [2*N-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_product;
  logic           r_valid;

  logic [N-1:0]   w_addend;
  logic [N-1:0]   w_sum;
  logic           w_cout;
  logic [2*N-1:0] w_acc_shift;
  logic           w_accept;
  logic           w_last_iter;

  // Gating the addend with ACC[0] folds the add/no-add choice into the adder.
  assign w_addend = r_acc[0] ? r_m : '0;

  mult_rca_adder #(.N(N)) u_adder (
    .i_a    (r_acc[2*N-1:N]),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The top accumulator bit is always zero after the shift, so it is not stored.
  assign w_acc_shift = {w_cout, w_sum, r_acc[N-1:1]};

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_last_iter = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last_iter) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Down-counter: loaded with N-1, last iteration runs when it reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_m   <= multiplicand;
      r_acc <= {{N{1'b0}}, multiplier};
      r_cnt <= CW'(N - 1);
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_shift;
      if (!w_last_iter) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_product <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_product <= r_acc;
      end
    end
  end

  assign product = r_product;
  assign valid   = r_valid;
endmodule

// File: tb/tb_mult_rca.sv
// Directed bench for mult_rca (N=32): vector table plus handshake corner cases.

module tb_mult_rca;
  localparam int N   = 32;
  localparam int LAT = N + 1;

  logic           clk;
  logic           reset;
  logic           start;
  logic [N-1:0]   multiplier;
  logic [N-1:0]   multiplicand;
  logic [2*N-1:0] product;
  logic           valid;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string        name;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [63:0]  p;
  } vec_t;

  vec_t vecs [8];

  mult_rca #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .product      (product),
    .valid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    multiplier   = a;
    multiplicand = b;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplier   = $urandom;
    multiplicand = $urandom;
  endtask

  task automatic wait_valid(input int limit, output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < limit) begin
      tick();
      edges++;
      if (valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] p);
    int e;
    bit seen;
    start_op(a, b);
    wait_valid(100, e, seen);
    check({name, "_valid_seen"}, 64'(seen), 64'd1);
    check({name, "_latency"}, 64'(e), 64'(LAT));
    check({name, "_product"}, product, p);
    tick();
    check({name, "_valid_width"}, 64'(valid), 64'd0);
    check({name, "_product_hold"}, product, p);
  endtask

  initial begin
    int  e;
    int  cnt;
    bit  seen;

    vecs[0] = '{"basic",   32'd1256,       32'd256,        64'd321536};
    vecs[1] = '{"max",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{"zero_a",  32'd0,          32'hDEAD_BEEF,  64'd0};
    vecs[3] = '{"one",     32'd1,          32'd1,          64'd1};
    vecs[4] = '{"zero_b",  32'hDEAD_BEEF,  32'd0,          64'd0};
    vecs[5] = '{"msb_x2",  32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
    vecs[6] = '{"max_x1",  32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
    vecs[7] = '{"sq_2p16", 32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};

    reset        = 1'b1;
    start        = 1'b0;
    multiplier   = '0;
    multiplicand = '0;

    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_product", product, 64'd0);
      check("rst_valid", 64'(valid), 64'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_product", product, 64'd0);
      check("post_rst_valid", 64'(valid), 64'd0);
    end

    // Start held for two cycles: second cycle lands in CALC and must not retrigger.
    multiplier   = 32'd1256;
    multiplicand = 32'd256;
    start        = 1'b1;
    tick();
    tick();
    start        = 1'b0;
    multiplier   = 32'd7;
    multiplicand = 32'd11;
    wait_valid(100, e, seen);
    check("hold2_valid_seen", 64'(seen), 64'd1);
    check("hold2_latency", 64'(e), 64'(LAT - 1));
    check("hold2_product", product, 64'h4E800);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid) cnt++;
    end
    check("hold2_no_second", 64'(cnt), 64'd0);
    check("hold2_product_hold", product, 64'h4E800);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].p);
    end

    // Start pulse during CALC is ignored.
    start_op(32'd7, 32'd9);
    repeat (5) tick();
    multiplier   = 32'd3;
    multiplicand = 32'd5;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    wait_valid(100, e, seen);
    check("busy_valid_seen", 64'(seen), 64'd1);
    check("busy_latency", 64'(e + 6), 64'(LAT));
    check("busy_product", product, 64'd63);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (valid) cnt++;
    end
    check("busy_no_second", 64'(cnt), 64'd0);
    check("busy_product_hold", product, 64'd63);

    // Reset mid-operation aborts it.
    start_op(32'd1256, 32'd256);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    check("midrst_product", product, 64'd0);
    check("midrst_valid", 64'(valid), 64'd0);
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (valid) cnt++;
    end
    check("midrst_no_valid", 64'(cnt), 64'd0);
    check("midrst_product_zero", product, 64'd0);
    run_op("after_rst", 32'd12, 32'd12, 64'd144);

    // Start held high continuously: one result every N+2 cycles.
    multiplier   = 32'd100;
    multiplicand = 32'd200;
    start        = 1'b1;
    wait_valid(100, e, seen);
    check("b2b_first_seen", 64'(seen), 64'd1);
    check("b2b_first_latency", 64'(e), 64'(LAT + 1));
    check("b2b_first_product", product, 64'd20000);
    for (int k = 0; k < 3; k++) begin
      wait_valid(100, e, seen);
      check("b2b_seen", 64'(seen), 64'd1);
      check("b2b_period", 64'(e), 64'(N + 2));
      check("b2b_product", product, 64'd20000);
    end
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid) cnt++;
    end
    check("b2b_stop", 64'(cnt), 64'd0);
    check("b2b_product_hold", product, 64'd20000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mult_rca.md
Name: mult_rca

Overview:
- Sequential radix-2 shift-and-add unsigned multiplier, one partial-product bit per cycle.
- Each addition uses an internal N-bit ripple-carry adder built as a chain of full-adder cells.
- Accepts an operand pair on a start strobe and returns a 2N-bit product with a one-cycle valid pulse.
- Sits as a standalone arithmetic block with a simple start/valid handshake.

Parameters:
- N, 32, operand width in bits (N >= 2); product is 2N bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- multiplier  input  N  unsigned operand A; captured when start is accepted.
- multiplicand  input  N  unsigned operand B; captured when start is accepted.
- product  output  2N  registered unsigned result A*B; holds the last result.
- valid  output  1  one-cycle pulse marking a new product.

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a rising edge with reset=1, state<=IDLE, product<=0, valid<=0, and internal accumulator and counter are cleared. Reset overrides start.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at an edge:
  - Capture multiplicand into register M.
  - Load accumulator ACC (2N+1 bits) = {(N+1)'b0, multiplier}.
  - Clear the count; go to CALC.
  - Operands may change after this edge.
- IDLE, start=0: hold. product keeps its last value; valid=0.
- CALC, one iteration per edge:
  - s = ACC[0] ? RCA(ACC[2N-1:N], M, cin=0) : {1'b0, ACC[2N-1:N]} (N-bit sum plus carry-out).
  - ACC <= {1'b0, s(N+1 bits), ACC[N-1:1]}, i.e. logical right shift of {carry, sum, low half}.
  - After exactly N iterations go to DONE.
- DONE, one edge: product <= ACC[2N-1:0]; valid <= 1; go to IDLE.
- valid deasserts at the following edge. It is high for exactly one cycle per accepted start.
- Latency: if start is sampled at edge E0, product and valid update at edge E(N+1). For N=32, valid is high in the cycle after edge 33.
- start during CALC or DONE is ignored; the operation in flight is unaffected. A start held high across the accept edge does not retrigger until the block is back in IDLE.
- If start is still high in the first IDLE cycle after DONE, a new operation begins. Back-to-back throughput is one result per N+2 cycles.
- Arithmetic is unsigned and exact: the product never overflows 2N bits. 0 operands yield 0.
- Reset mid-operation aborts the operation: no valid pulse, product=0, block returns to IDLE.
- The RCA is a generic N-bit chain of full adders: sum = a^b^c, cout = ab|ac|bc, carry rippling from LSB.

Test Plan:
- Reset: assert reset for 5 cycles -> product=0, valid=0 throughout and after release with start=0.
- Basic: start=1 for 2 cycles with multiplier=1256, multiplicand=256, then operands and start=0 -> exactly one valid pulse 33 edges after the accept edge, product=321536 (0x4E800), held afterwards.
- Extremes: multiplier=multiplicand=0xFFFFFFFF -> product=0xFFFFFFFE00000001. 0 x 0xDEADBEEF -> product=0. 1 x 1 -> product=1.
- Busy ignore: accept 7x9, then pulse start with 3x5 during CALC -> single valid, product=63, no second result.
- Reset mid-op: accept 1256x256, assert reset 10 cycles later -> no valid pulse, product=0, state IDLE. A new start with 12x12 then gives 144.
- Back-to-back: hold start high continuously with 100x200 -> valid pulses every 34 cycles, product=20000 each time.
